arb_mux: RTL and testbench

Parametrised N-channel registered multiplexer with valid/ready handshaking, selectable between fixed-select mode and round-robin arbitration. It generalises the combinational select-by-index muxes in the datapath to streaming sources that may stall, such as instruction fetch, data access and debug ports competing for one memory or bus port. It provides one output register stage, full throughput, and a per-beat channel tag.

---
 rtl/arb_mux_if.sv | 29 ++
 rtl/arb_mux.sv | 96 +++++++++
 tb/tb_arb_mux.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/arb_mux_if.sv
// Bus bundle for arb_mux: N streaming input channels and one registered
// output stream with a channel tag. The slave modport is the mux side and
// the master modport is the side that drives the sources and sinks.
interface arb_mux_if #(
   parameter int WIDTH = 8,
   parameter int N     = 7
);
   localparam int SELW = (N > 1) ? $clog2(N) : 1;

   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_ch;
   logic                 out_ready;

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/arb_mux.sv
// N-channel registered multiplexer with valid/ready handshaking.
// mode=0 serves only the channel picked by sel (channel 0 if sel is out of
// range); mode=1 arbitrates round-robin starting after the last served
// channel. One output register stage, one beat per cycle, per-beat tag.
module arb_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 7
) (
   input  logic       clk,
   input  logic       rst,
   arb_mux_if.slave   bus
);
   localparam int SELW = (N > 1) ? $clog2(N) : 1;
   localparam int NPOW = 1 << SELW;
   localparam logic [SELW:0] C_N = (SELW+1)'(N);
   localparam logic [SELW-1:0] C_PTR_RST = SELW'(N - 1);

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SELW-1:0]     r_out_ch;
   logic [SELW-1:0]     r_ptr;

   logic                w_load;
   logic                w_grant_any;
   logic [SELW-1:0]     w_grant_idx;
   logic [SELW-1:0]     w_cand;
   logic [SELW:0]       w_sum;
   logic [WIDTH-1:0]    w_ch_data [NPOW];

   // The output register can accept a beat when empty or being drained.
   assign w_load = !r_out_valid || bus.out_ready;

   // Unpack the flat input bus; index slots past N-1 read as zero so the
   // array can be addressed by any SELW-bit value.
   for (genvar gi = 0; gi < NPOW; gi++) begin : g_unpack
      if (gi < N) begin : g_real
         assign w_ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
         assign w_ch_data[gi] = '0;
      end
   end

   // Grant selection: fixed candidate in mode 0, rotating search in mode 1.
   // The search runs from the farthest offset down to ptr+1 so that the
   // nearest valid channel after ptr is the one left standing.
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      w_sum       = '0;
      w_cand      = ({1'b0, bus.sel} >= C_N) ? '0 : bus.sel;
      if (!bus.mode) begin
         w_grant_any = bus.in_valid[w_cand];
         w_grant_idx = w_cand;
      end else begin
         for (int k = N; k >= 1; k--) begin
            w_sum = {1'b0, r_ptr} + (SELW+1)'(k);
            if (w_sum >= C_N) begin
               w_sum = w_sum - C_N;
            end
            if (bus.in_valid[w_sum[SELW-1:0]]) begin
               w_grant_any = 1'b1;
               w_grant_idx = w_sum[SELW-1:0];
            end
         end
      end
   end

   // One-hot ready towards the granted channel, suppressed during reset.
   for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign bus.in_ready[gi] = w_load && w_grant_any && !rst &&
                                (w_grant_idx == SELW'(gi));
   end

   // Output register and round-robin pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= C_PTR_RST;
      end else if (w_load) begin
         if (w_grant_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ch_data[w_grant_idx];
            r_out_ch    <= w_grant_idx;
            r_ptr       <= w_grant_idx;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ch    = r_out_ch;
endmodule

// File: tb/tb_arb_mux.sv
// Directed, table-driven bench for arb_mux (WIDTH=8, N=7). Each vector sets
// mode/sel/in_valid/out_ready, checks in_ready before the edge and the
// output register after it. Reset behaviour is exercised by hand.
module tb_arb_mux;
   localparam int WIDTH = 8;
   localparam int N     = 7;

   typedef struct {
      logic       mode;
      logic [2:0] sel;
      logic [6:0] iv;
      logic       ordy;
      logic [6:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_d;
      logic [2:0] exp_ch;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] dat [N];
   vec_t vq[$];
   int n_vec = 0;
   int n_err = 0;

   arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

   arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic mode, input logic [2:0] sel, input logic [6:0] iv,
                      input logic ordy, input logic [6:0] erdy, input logic eov,
                      input logic [7:0] ed, input logic [2:0] ech);
      vec_t v;
      v.mode = mode; v.sel = sel; v.iv = iv; v.ordy = ordy;
      v.exp_rdy = erdy; v.exp_ov = eov; v.exp_d = ed; v.exp_ch = ech;
      vq.push_back(v);
   endtask

   // Applies every queued vector starting at a falling edge, then empties it.
   task automatic run_table();
      for (int i = 0; i < vq.size(); i++) begin
         bus.mode      = vq[i].mode;
         bus.sel       = vq[i].sel;
         bus.in_valid  = vq[i].iv;
         bus.out_ready = vq[i].ordy;
         #1;
         check("in_ready", 64'(bus.in_ready), 64'(vq[i].exp_rdy));
         @(posedge clk);
         #1;
         check("out_valid", 64'(bus.out_valid), 64'(vq[i].exp_ov));
         check("out_data", 64'(bus.out_data), 64'(vq[i].exp_d));
         check("out_ch", 64'(bus.out_ch), 64'(vq[i].exp_ch));
         $display("vec mode=%0d sel=%0d iv=%07b ordy=%0d -> rdy=%07b ov=%0d d=%02h ch=%0d",
                  vq[i].mode, vq[i].sel, vq[i].iv, vq[i].ordy,
                  bus.in_ready, bus.out_valid, bus.out_data, bus.out_ch);
         @(negedge clk);
      end
      vq.delete();
   endtask

   initial begin
      dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h3C; dat[3] = 8'hA5;
      dat[4] = 8'h44; dat[5] = 8'h55; dat[6] = 8'h66;
      rst           = 1'b1;
      bus.mode      = 1'b0;
      bus.sel       = 3'd0;
      bus.in_valid  = 7'h7F;
      bus.in_data   = {8'h66, 8'h55, 8'h44, 8'hA5, 8'h3C, 8'h22, 8'h11};
      bus.out_ready = 1'b1;

      // Reset state with every channel valid: nothing may be granted.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_ch", 64'(bus.out_ch), 64'd0);
      $display("reset: rdy=%07b ov=%0d d=%02h ch=%0d",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_ch);
      rst = 1'b0;

      // Fixed mode, sel=3.
      add(1'b0, 3'd3, 7'h7F, 1'b1, 7'b0001000, 1'b1, 8'hA5, 3'd3);
      run_table();

      // Reset asserted while a beat is held: cleared at once, no ready.
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_out_data", 64'(bus.out_data), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      $display("mid-reset: rdy=%07b ov=%0d d=%02h",
               bus.in_ready, bus.out_valid, bus.out_data);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Out-of-range select falls back to channel 0; then no grant drains.
      add(1'b0, 3'd7, 7'b0000001, 1'b1, 7'b0000001, 1'b1, 8'h11, 3'd0);
      add(1'b0, 3'd7, 7'b1111110, 1'b1, 7'b0000000, 1'b0, 8'h11, 3'd0);
      // Park the pointer on channel 6, then 14 round-robin beats.
      add(1'b0, 3'd6, 7'h7F, 1'b1, 7'b1000000, 1'b1, 8'h66, 3'd6);
      for (int i = 0; i < 14; i++) begin
         add(1'b1, 3'd0, 7'h7F, 1'b1, 7'(1 << (i % 7)), 1'b1, dat[i % 7], 3'(i % 7));
      end
      // Sparse round-robin after channel 5: 6, 2, 6.
      add(1'b0, 3'd5, 7'h7F, 1'b1, 7'b0100000, 1'b1, 8'h55, 3'd5);
      add(1'b1, 3'd0, 7'b1000100, 1'b1, 7'b1000000, 1'b1, 8'h66, 3'd6);
      add(1'b1, 3'd0, 7'b1000100, 1'b1, 7'b0000100, 1'b1, 8'h3C, 3'd2);
      add(1'b1, 3'd0, 7'b1000100, 1'b1, 7'b1000000, 1'b1, 8'h66, 3'd6);
      // Backpressure: load 3C from channel 2, hold 4 cycles, then reload.
      add(1'b0, 3'd2, 7'h7F, 1'b1, 7'b0000100, 1'b1, 8'h3C, 3'd2);
      for (int i = 0; i < 4; i++) begin
         add(1'b1, 3'd0, 7'h7F, 1'b0, 7'b0000000, 1'b1, 8'h3C, 3'd2);
      end
      add(1'b1, 3'd0, 7'h7F, 1'b1, 7'b0001000, 1'b1, 8'hA5, 3'd3);
      // Mode switch from RR with ptr=2: expect 1,1,2,3.
      add(1'b0, 3'd2, 7'h7F, 1'b1, 7'b0000100, 1'b1, 8'h3C, 3'd2);
      add(1'b0, 3'd1, 7'h7F, 1'b1, 7'b0000010, 1'b1, 8'h22, 3'd1);
      add(1'b0, 3'd1, 7'h7F, 1'b1, 7'b0000010, 1'b1, 8'h22, 3'd1);
      add(1'b1, 3'd1, 7'h7F, 1'b1, 7'b0000100, 1'b1, 8'h3C, 3'd2);
      add(1'b1, 3'd1, 7'h7F, 1'b1, 7'b0001000, 1'b1, 8'hA5, 3'd3);
      run_table();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
